// File: rtl/lcd_write_sequencer_if.sv
// rtl/lcd_write_sequencer_if.sv - host-side write handshake between port decode and LCD sequencer
interface lcd_write_sequencer_if;
    logic       req;
    logic       req_rs;
    logic [7:0] req_data;
    logic       ack;
    logic       busy;
    logic       init_done;

    modport master (
        output req,
        output req_rs,
        output req_data,
        input  ack,
        input  busy,
        input  init_done
    );

    modport slave (
        input  req,
        input  req_rs,
        input  req_data,
        output ack,
        output busy,
        output init_done
    );
endinterface

// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780 8-bit write sequencer with built-in power-up init
module lcd_write_sequencer #(
    parameter int POWERUP_CYCLES    = 500000,
    parameter int SETUP_CYCLES      = 2,
    parameter int E_PULSE_CYCLES    = 12,
    parameter int HOLD_CYCLES       = 2,
    parameter int CMD_WAIT_CYCLES   = 1000,
    parameter int CLEAR_WAIT_CYCLES = 41000
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_write_sequencer_if.slave  host,
    output logic [7:0]            lcd_d,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_e
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYCLES = max2(max2(max2(POWERUP_CYCLES, SETUP_CYCLES),
                                          max2(E_PULSE_CYCLES, HOLD_CYCLES)),
                                     max2(CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES));
    localparam int CW = $clog2(MAX_CYCLES + 1);

    // Each phase counts up from 0 and ends on the cycle its counter reaches N-1.
    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

    localparam logic [2:0] INIT_LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_LOAD,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = 8'h38;
            3'd1:    val = 8'h38;
            3'd2:    val = 8'h38;
            3'd3:    val = 8'h0C;
            3'd4:    val = 8'h01;
            3'd5:    val = 8'h06;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      lcd_d_q, lcd_d_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_e_q, lcd_e_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            init_done_q, init_done_d;
    logic            is_clear;
    logic [CW-1:0]   wait_last;

    // Clear display and return home need the long settle time.
    assign is_clear  = !lcd_rs_q && (lcd_d_q <= 8'h03);
    assign wait_last = is_clear ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lcd_d_d     = lcd_d_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_e_d     = lcd_e_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        init_done_d = init_done_q;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT_LOAD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT_LOAD: begin
                lcd_rs_d = 1'b0;
                lcd_d_d  = init_rom(idx_q);
                state_d  = S_SETUP;
                cnt_d    = '0;
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (host.req) begin
                    ack_d    = 1'b1;
                    busy_d   = 1'b1;
                    lcd_rs_d = host.req_rs;
                    lcd_d_d  = host.req_data;
                    state_d  = S_SETUP;
                    cnt_d    = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_E_HIGH;
                    lcd_e_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_E_HIGH: begin
                if (cnt_q == E_LAST) begin
                    state_d = S_HOLD;
                    lcd_e_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    // init_done is sticky, so it also tells init writes from user writes.
                    if (!init_done_q && (idx_q != INIT_LAST_IDX)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_INIT_LOAD;
                    end else begin
                        init_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_PWR_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            lcd_d_q     <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lcd_d_q     <= lcd_d_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    assign lcd_d          = lcd_d_q;
    assign lcd_rs         = lcd_rs_q;
    assign lcd_e          = lcd_e_q;
    assign lcd_rw         = 1'b0;
    assign host.ack       = ack_q;
    assign host.busy      = busy_q;
    assign host.init_done = init_done_q;

endmodule
